// File: rtl/icb_mst_seq.sv
// ---------------------------------------------------------------------------
// icb_mst_seq
//   Command-sequencing ICB master. Host commands (read or write) are queued in
//   a small FIFO. The sequencer issues them one at a time on the ICB write or
//   read channel, waits for the matching acknowledge (with a timeout), and then
//   presents one response per command on the rsp_* handshake.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_wr, cmd_adr, cmd_wdat      command fields (1 = write)
//   icb_wr, icb_wadr, icb_wdat     ICB write request / address / data
//   icb_wack                       ICB write acknowledge
//   icb_rd, icb_radr               ICB read request / address
//   icb_rdat, icb_rack             ICB read data / acknowledge
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdat, rsp_err              read data (0 for writes/timeouts), timeout flag
//   busy                           queue non-empty or a command in progress
// ---------------------------------------------------------------------------
module icb_mst_seq #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int TMO   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_adr,
    input  logic [31:0]   cmd_wdat,
    output logic          icb_wr,
    output logic [AW-1:0] icb_wadr,
    output logic [31:0]   icb_wdat,
    input  logic          icb_wack,
    output logic          icb_rd,
    output logic [AW-1:0] icb_radr,
    input  logic [31:0]   icb_rdat,
    input  logic          icb_rack,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdat,
    output logic          rsp_err,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 33;                   // {wr, adr, wdat}
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [31:0]     rsp_rdat_q, rsp_rdat_d;
    logic            rsp_err_q, rsp_err_d;

    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;

    // Readiness depends only on the current fill level, so a full FIFO refuses
    // a command even in a cycle where the sequencer pops its head.
    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];

    // Storage needs no reset: entries are only read once the count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_wr, cmd_adr, cmd_wdat};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state logic. The acknowledge check precedes the timeout check so an
    // ack on the last allowed cycle still completes normally.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rsp_rdat_d = rsp_rdat_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    adr_d   = head[EW-2 -: AW];
                    wdat_d  = head[31:0];
                    tmo_d   = '0;
                    state_d = head[EW-1] ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (icb_wack) begin
                    rsp_rdat_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RSP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_rdat_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RD: begin
                if (icb_rack) begin
                    rsp_rdat_d = icb_rdat;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RSP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_rdat_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rsp_rdat_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rsp_rdat_q <= rsp_rdat_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Request fields are forced to zero outside their own state so nothing
    // stale is ever visible on an idle channel.
    assign icb_wr    = (state_q == S_WR);
    assign icb_rd    = (state_q == S_RD);
    assign icb_wadr  = icb_wr ? adr_q  : '0;
    assign icb_wdat  = icb_wr ? wdat_q : '0;
    assign icb_radr  = icb_rd ? adr_q  : '0;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_rdat  = rsp_rdat_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_icb_mst_seq.sv
module tb_icb_mst_seq;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_wdat = '0;
    logic          icb_wr;
    logic [AW-1:0] icb_wadr;
    logic [31:0]   icb_wdat;
    logic          icb_wack = 1'b0;
    logic          icb_rd;
    logic [AW-1:0] icb_radr;
    logic [31:0]   icb_rdat = '0;
    logic          icb_rack = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdat;
    logic          rsp_err;
    logic          busy;

    always #5 clk = ~clk;

    icb_mst_seq #(.AW(AW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_adr(cmd_adr), .cmd_wdat(cmd_wdat),
        .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack),
        .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural model: a queue of accepted commands plus one command being
    // served, in phase 0 (waiting), 1 (on the bus) or 2 (response offered).
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] adr;
        logic [31:0]   wdat;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        m_cur;
    int          m_phase = 0;
    int          m_age = 0;
    logic [31:0] m_rdat = '0;
    logic        m_err = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // Stimulus applied at the next step
    logic          nxt_rst = 1'b1;
    logic          nxt_valid = 1'b0;
    logic          nxt_wr = 1'b0;
    logic [AW-1:0] nxt_adr = '0;
    logic [31:0]   nxt_wdat = '0;
    logic          nxt_rsp_ready = 1'b1;

    // Slave behaviour
    int          sl_wait = 0;
    logic        sl_never = 1'b0;
    logic        sl_rand = 1'b0;
    logic        sl_noise = 1'b0;
    logic [31:0] sl_rdat = '0;
    int          req_cyc = 0;

    // Observations of DUT activity used by directed checks
    int          wr_hi = 0;
    int          rd_hi = 0;
    int          rsp_seen = 0;
    int          accepted = 0;
    logic [31:0] last_rdat = '0;
    logic        last_err = 1'b0;
    logic [31:0] first_wdat = '0;
    logic        prev_req = 1'b0;
    logic [AW-1:0] req_log[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic clear_obs();
        wr_hi = 0; rd_hi = 0; rsp_seen = 0; accepted = 0;
        last_rdat = '0; last_err = 1'b0; first_wdat = '0;
        req_log.delete();
    endtask

    // Compare DUT outputs with the model, record observations, then advance
    // the model using the inputs that will be sampled at the next rising edge.
    task automatic compare_and_advance();
        logic req;
        logic ack;
        int   pre;
        if (rst) begin
            chk("rst_icb_wr", icb_wr, 0);
            chk("rst_icb_rd", icb_rd, 0);
            chk("rst_icb_wadr", icb_wadr, 0);
            chk("rst_icb_wdat", icb_wdat, 0);
            chk("rst_icb_radr", icb_radr, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdat", rsp_rdat, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            mq.delete();
            m_phase = 0;
            m_age = 0;
            prev_req = 1'b0;
            return;
        end
        req = (m_phase == 1);
        chk("icb_wr", icb_wr, req && m_cur.wr);
        chk("icb_rd", icb_rd, req && !m_cur.wr);
        chk("icb_wadr", icb_wadr, (req && m_cur.wr) ? m_cur.adr : '0);
        chk("icb_wdat", icb_wdat, (req && m_cur.wr) ? m_cur.wdat : '0);
        chk("icb_radr", icb_radr, (req && !m_cur.wr) ? m_cur.adr : '0);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("rsp_rdat", rsp_rdat, m_rdat);
            chk("rsp_err", rsp_err, m_err);
        end
        chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
        chk("busy", busy, (mq.size() != 0) || (m_phase != 0));

        if (icb_wr) wr_hi++;
        if (icb_rd) rd_hi++;
        if ((icb_wr || icb_rd) && !prev_req) begin
            req_log.push_back(icb_wr ? icb_wadr : icb_radr);
            if (icb_wr) first_wdat = icb_wdat;
        end
        prev_req = icb_wr || icb_rd;
        if (rsp_valid) begin
            rsp_seen++;
            last_rdat = rsp_rdat;
            last_err = rsp_err;
        end
        if (cmd_valid && cmd_ready) accepted++;

        pre = mq.size();
        case (m_phase)
            0: if (pre > 0) begin
                m_cur = mq.pop_front();
                m_phase = 1;
                m_age = 0;
            end
            1: begin
                ack = m_cur.wr ? icb_wack : icb_rack;
                if (ack) begin
                    m_phase = 2;
                    m_rdat = m_cur.wr ? 32'h0 : icb_rdat;
                    m_err = 1'b0;
                end else if (m_age + 1 >= TMO) begin
                    m_phase = 2;
                    m_rdat = 32'h0;
                    m_err = 1'b1;
                end else begin
                    m_age++;
                end
            end
            default: if (rsp_ready) m_phase = 0;
        endcase
        if (cmd_valid && pre < DEPTH) begin
            mq.push_back('{wr: cmd_wr, adr: cmd_adr, wdat: cmd_wdat});
        end
    endtask

    task automatic step();
        logic hit;
        @(posedge clk);
        #1;
        rst       = nxt_rst;
        cmd_valid = nxt_valid;
        cmd_wr    = nxt_wr;
        cmd_adr   = nxt_adr;
        cmd_wdat  = nxt_wdat;
        rsp_ready = nxt_rsp_ready;
        #1;
        hit = 1'b0;
        if (icb_wr || icb_rd) begin
            hit = !sl_never && (req_cyc == sl_wait);
            req_cyc++;
        end else begin
            req_cyc = 0;
            if (sl_rand) begin
                sl_wait  = $urandom_range(0, TMO + 3);
                sl_never = 1'b0;
            end
        end
        icb_rdat = sl_rand ? $urandom : sl_rdat;
        icb_wack = (icb_wr && hit) || (sl_noise && !icb_wr && ($urandom_range(0, 3) == 0));
        icb_rack = (icb_rd && hit) || (sl_noise && !icb_rd && ($urandom_range(0, 3) == 0));
        @(negedge clk);
        compare_and_advance();
    endtask

    task automatic run_until_idle(input int budget);
        nxt_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (i >= 2 && !busy) break;
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic push_cmd(input logic wr, input logic [AW-1:0] adr, input logic [31:0] wdat);
        nxt_valid = 1'b1;
        nxt_wr    = wr;
        nxt_adr   = adr;
        nxt_wdat  = wdat;
        step();
        nxt_valid = 1'b0;
    endtask

    initial begin
        int saved;
        // Reset phase
        nxt_rst = 1'b1;
        step();
        step();
        nxt_rst = 1'b0;
        step();
        $display("reset: cmd_ready=%0d busy=%0d", cmd_ready, busy);

        // Write, zero-wait slave
        clear_obs();
        sl_wait = 0; sl_never = 0; sl_rdat = 32'hDEAD_BEEF; nxt_rsp_ready = 1'b1;
        push_cmd(1'b1, 8'h04, 32'h0000_00A5);
        run_until_idle(50);
        chk("A_wr_cycles", wr_hi, 1);
        chk("A_nreq", req_log.size(), 1);
        if (req_log.size() > 0) chk("A_wadr", req_log[0], 8'h04);
        chk("A_wdat", first_wdat, 32'hA5);
        chk("A_err", last_err, 0);
        chk("A_rdat", last_rdat, 0);
        $display("write 0x04: wr_cycles=%0d rsp_err=%0d rsp_rdat=0x%0h", wr_hi, last_err, last_rdat);

        // Read with 3 wait cycles
        clear_obs();
        sl_wait = 3; sl_rdat = 32'h0000_1234;
        push_cmd(1'b0, 8'h08, 32'h0);
        run_until_idle(50);
        chk("B_rd_cycles", rd_hi, 4);
        chk("B_rdat", last_rdat, 32'h1234);
        chk("B_err", last_err, 0);
        $display("read 0x08 wait3: rd_cycles=%0d rsp_rdat=0x%0h err=%0d", rd_hi, last_rdat, last_err);

        // Read timeout
        clear_obs();
        sl_never = 1'b1; sl_rdat = 32'h5555_AAAA;
        push_cmd(1'b0, 8'h0C, 32'h0);
        run_until_idle(80);
        chk("C_rd_cycles", rd_hi, TMO);
        chk("C_err", last_err, 1);
        chk("C_rdat", last_rdat, 0);
        $display("read timeout: rd_cycles=%0d err=%0d rdat=0x%0h", rd_hi, last_err, last_rdat);

        // Ack on the last allowed cycle wins over the timeout
        clear_obs();
        sl_never = 1'b0; sl_wait = TMO - 1; sl_rdat = 32'hCAFE_F00D;
        push_cmd(1'b0, 8'h10, 32'h0);
        run_until_idle(80);
        chk("D_rd_cycles", rd_hi, TMO);
        chk("D_err", last_err, 0);
        chk("D_rdat", last_rdat, 32'hCAFE_F00D);
        $display("read ack at cycle %0d: err=%0d rdat=0x%0h", rd_hi, last_err, last_rdat);

        // Back-to-back pushes with the response stalled
        clear_obs();
        sl_wait = 0; nxt_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nxt_valid = 1'b1;
            nxt_wr    = i[0];
            nxt_adr   = 8'h20 + 8'(i);
            nxt_wdat  = 32'h100 + i;
            step();
        end
        chk("E_accepted", accepted, 5);
        chk("E_full", cmd_ready, 0);
        nxt_rsp_ready = 1'b1;
        run_until_idle(200);
        chk("E_nreq", req_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < req_log.size()) chk("E_order", req_log[i], 8'h20 + 8'(i));
        end
        $display("burst: accepted=%0d requests=%0d", accepted, req_log.size());

        // Reset while a write waits with two commands queued
        clear_obs();
        sl_never = 1'b1;
        push_cmd(1'b1, 8'h30, 32'h1);
        push_cmd(1'b1, 8'h31, 32'h2);
        push_cmd(1'b1, 8'h32, 32'h3);
        step();
        chk("F_pre_wr", icb_wr, 1);
        nxt_rst = 1'b1;
        step();
        chk("F_wr_after_rst", icb_wr, 0);
        chk("F_busy_after_rst", busy, 0);
        nxt_rst = 1'b0;
        saved = rsp_seen;
        for (int i = 0; i < 20; i++) step();
        chk("F_no_rsp", rsp_seen - saved, 0);
        chk("F_idle", busy, 0);
        $display("reset mid-write: busy=%0d responses_after=%0d", busy, rsp_seen - saved);

        // Randomized traffic with wrong-channel ack noise
        sl_never = 1'b0; sl_rand = 1'b1; sl_noise = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            nxt_valid     = ($urandom_range(0, 2) == 0);
            nxt_wr        = $urandom_range(0, 1) == 1;
            nxt_adr       = 8'($urandom);
            nxt_wdat      = $urandom;
            nxt_rsp_ready = ($urandom_range(0, 3) != 0);
            nxt_rst       = (i == 1500);
            step();
        end
        nxt_rst = 1'b0;
        nxt_rsp_ready = 1'b1;
        run_until_idle(500);
        $display("random traffic done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
